ddr_weight_reader: RTL and testbench
====================================

// Module: ddr_weight_reader
// PURPOSE
//  Upstream DDR read engine feeding the weight FIFO controller. Takes the start
//  address, byte length and config pulse (ddr_st_addr_out/ddr_len/ddr_conf).
//  Splits the transfer into bursts on a simple memory read port and buffers the
//  returned 512-bit beats in a FWFT FIFO. Exposes that FIFO as empty/req/data.
// PARAMETERS
//  DDR_ADDR_LEN 32  byte-address width
//  SINGLE_LEN   24  byte-length width
//  DATA_W       512 beat width (64 B/beat)
//  FIFO_DEPTH   64  beat FIFO depth, power of 2
//  MAX_BURST    16  max beats per read request, power of 2, <= FIFO_DEPTH
// PORTS
//  clk            in  1            clock
//  rst_n          in  1            sync active-low reset
//  conf           in  1            1-cycle start pulse
//  ddr_st_addr    in  DDR_ADDR_LEN start byte address, bits[5:0] ignored (treated 0)
//  ddr_len        in  SINGLE_LEN   transfer length in bytes
//  rd_req_valid   out 1            read request valid
//  rd_req_ready   in  1            read request accepted
//  rd_req_addr    out DDR_ADDR_LEN burst byte address, 64 B aligned
//  rd_req_beats   out 8            burst length in beats, 1..MAX_BURST
//  rd_resp_valid  in  1            response beat valid, in order
//  rd_resp_data   in  DATA_W       response beat
//  ddr_fifo_empty out 1            FIFO empty
//  ddr_fifo_req   in  1            pop request from consumer
//  ddr_fifo_data  out DATA_W       FIFO head, valid while !ddr_fifo_empty
//  idle           out 1            high in IDLE state
// BEHAVIOUR
//  - Reset values: rd_req_valid=0, rd_req_addr=0, rd_req_beats=0, ddr_fifo_empty=1,
//    ddr_fifo_data=0, idle=1. Reset also flushes the FIFO, credit and outstanding counters.
//  - Beats = ceil(ddr_len/64), computed in SINGLE_LEN bits. conf with len=0 -> stay IDLE.
//  - FSM IDLE -> ISSUE on conf&&len!=0. conf is ignored outside IDLE.
//  - ISSUE -> DRAIN when the last request handshakes.
//  - DRAIN -> IDLE when outstanding==0 (all beats written into the FIFO).
//  - Burst size = min(remaining, MAX_BURST, beats left to the next 4 KB boundary).
//    Bursts never cross 4 KB.
//  - Credit rule: rd_req_valid only if free = FIFO_DEPTH-count-outstanding >= burst.
//    outstanding grows by burst at handshake, shrinks by 1 per rd_resp_valid.
//  - Hence responses are always accepted (no resp ready). rd_resp_valid in IDLE is dropped.
//  - Once raised, rd_req_valid/addr/beats hold stable until rd_req_ready.
//    Handshake = valid&&ready. The next request may assert the following cycle.
//  - FIFO is FWFT. Pop when ddr_fifo_req && !ddr_fifo_empty.
//    Write-to-visible latency is 1 cycle: beat at edge N, !empty after edge N+1.
//  - Simultaneous push/pop: count unchanged.
//  - Pop when empty is ignored. Pointers wrap modulo FIFO_DEPTH.
//  - Beat order out equals DDR address order.
//  - Reset mid-operation returns to IDLE the next cycle. Beats arriving after reset are dropped.
//  - idle is the FSM state only; the FIFO may still hold data when idle=1.
// CONFIGURATION
//  DDR_WEIGHT_READER_STATS_EN defined: adds outputs stat_beats[31:0], the beats
//    pushed, and stat_stall[31:0], cycles in ISSUE with valid held off by credit.
//    Both clear on conf and on reset, and saturate at all-ones.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  ddr_rd_pkg: BEAT_BYTES=64, BEAT_SHIFT=6, PAGE_BYTES=4096, state enum {IDLE,ISSUE,DRAIN}.
//  Sub-module sync_fifo_fwft (DATA_W, FIFO_DEPTH) with push/pop/empty/full/count.
//  Burst splitter, credit logic and FSM stay in the top.
// TESTING
//  1 conf addr=0x1000 len=4096, ready=1, 3-cyc resp latency -> 4 reqs of 16 beats
//    at 0x1000/0x1400/0x1800/0x1C00; 64 beats out in order; idle returns.
//  2 addr=0x0FC0 len=200 -> bursts {1 beat @0x0FC0, 3 beats @0x1000}; beats=ceil(200/64)=4.
//  3 consumer req held 0, len=8192 -> exactly 64 beats requested and none further.
//    Releasing req resumes issue; no FIFO overflow.
//  4 len=0 -> no request, idle stays 1. conf during ISSUE -> ignored, original transfer intact.
//  5 rd_req_ready low for 5 cycles -> valid/addr/beats stable until handshake.
//  6 rst_n low mid-transfer for 1 cycle -> empty=1, idle=1, valid=0. New conf works normally.

Source files
------------

// File: rtl/ddr_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ddr_rd_pkg
//  Description : Shared constants and FSM state type for the DDR weight reader.
//  Revision    : 1.0  initial release
// ============================================================================
package ddr_rd_pkg;

  localparam int BEAT_BYTES = 64;     // bytes per 512-bit beat
  localparam int BEAT_SHIFT = 6;      // log2(BEAT_BYTES)
  localparam int PAGE_BYTES = 4096;   // bursts never cross this boundary
  localparam int PAGE_SHIFT = 12;     // log2(PAGE_BYTES)
  localparam int PAGE_BEATS = PAGE_BYTES / BEAT_BYTES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage : ddr_rd_pkg
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_fwft
//  Description : Single-clock first-word-fall-through FIFO. Head word is
//                presented combinationally; output reads zero while empty.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_fwft #(
  parameter int DATA_W     = 512,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic [DATA_W-1:0]               push_data,
  input  logic                            pop,
  output logic [DATA_W-1:0]               pop_data,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH):0]     count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Zero when empty so the head output has a defined reset value.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write; the array carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : sync_fifo_fwft
`default_nettype wire

// File: rtl/ddr_weight_reader.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_weight_reader
//  Description : DDR read engine. Splits a byte-length transfer into bursts
//                (<= MAX_BURST beats, never crossing 4 KB), issues them only
//                when the beat FIFO has room for every outstanding beat, and
//                buffers returned beats in a FWFT FIFO for the consumer.
//                Optional macro DDR_WEIGHT_READER_STATS_EN adds stat_beats and
//                stat_stall counters.
//  Revision    : 1.0  initial release
// ============================================================================
module ddr_weight_reader
  import ddr_rd_pkg::*;
#(
  parameter int DDR_ADDR_LEN = 32,
  parameter int SINGLE_LEN   = 24,
  parameter int DATA_W       = 512,
  parameter int FIFO_DEPTH   = 64,
  parameter int MAX_BURST    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    conf,
  input  logic [DDR_ADDR_LEN-1:0] ddr_st_addr,
  input  logic [SINGLE_LEN-1:0]   ddr_len,
  output logic                    rd_req_valid,
  input  logic                    rd_req_ready,
  output logic [DDR_ADDR_LEN-1:0] rd_req_addr,
  output logic [7:0]              rd_req_beats,
  input  logic                    rd_resp_valid,
  input  logic [DATA_W-1:0]       rd_resp_data,
  output logic                    ddr_fifo_empty,
  input  logic                    ddr_fifo_req,
  output logic [DATA_W-1:0]       ddr_fifo_data,
  output logic                    idle
`ifdef DDR_WEIGHT_READER_STATS_EN
  ,
  output logic [31:0]             stat_beats,
  output logic [31:0]             stat_stall
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                  state;
  state_t                  state_n;
  logic [DDR_ADDR_LEN-1:0] cur_addr;
  logic [SINGLE_LEN-1:0]   rem;
  logic [CNT_W-1:0]        outst;
  logic                    resp_q_valid;
  logic [DATA_W-1:0]       resp_q_data;

  logic [SINGLE_LEN-1:0]   len_beats;
  logic [DDR_ADDR_LEN-1:0] start_addr;
  logic                    start;
  logic [SINGLE_LEN-1:0]   page_left;
  logic [SINGLE_LEN-1:0]   burst_cap;
  logic [SINGLE_LEN-1:0]   burst;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_full;
  logic [CNT_W-1:0]        free;
  logic                    credit_ok;
  logic                    hs;
  logic                    last_hs;
  logic                    resp_acc;
  logic                    fifo_push;
  logic                    fifo_pop;

  // Beat count is ceil(len/64) without forming len+63, so no carry is lost.
  assign len_beats  = (ddr_len >> BEAT_SHIFT) + SINGLE_LEN'(|ddr_len[BEAT_SHIFT-1:0]);
  assign start_addr = ddr_st_addr & ~DDR_ADDR_LEN'(BEAT_BYTES - 1);
  assign start      = (state == IDLE) && conf && (len_beats != '0);

  // Burst = min(remaining, MAX_BURST, beats left in the current 4 KB page).
  assign page_left = SINGLE_LEN'(PAGE_BEATS) - SINGLE_LEN'(cur_addr[PAGE_SHIFT-1:BEAT_SHIFT]);
  assign burst_cap = (page_left < SINGLE_LEN'(MAX_BURST)) ? page_left : SINGLE_LEN'(MAX_BURST);
  assign burst     = (rem < burst_cap) ? rem : burst_cap;

  // Space the FIFO can still promise: beats already queued, beats in the
  // input register and beats still owed by memory all consume a slot. Free
  // space never shrinks while a request waits, so valid stays up once raised.
  assign free      = CNT_W'(FIFO_DEPTH) - fifo_count - outst - CNT_W'(resp_q_valid);
  assign credit_ok = SINGLE_LEN'(free) >= burst;

  assign rd_req_valid = (state == ISSUE) && credit_ok;
  assign rd_req_addr  = cur_addr;
  assign rd_req_beats = (state == ISSUE) ? burst[7:0] : 8'd0;

  assign hs        = rd_req_valid && rd_req_ready;
  assign last_hs   = hs && (rem == burst);
  assign resp_acc  = rd_resp_valid && (state != IDLE);
  assign fifo_push = resp_q_valid && !fifo_full;
  assign fifo_pop  = ddr_fifo_req;
  assign idle      = (state == IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state: start on a non-empty conf, drain after the final request,
  // return to idle once every requested beat has landed in the FIFO.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = ISSUE;
      ISSUE:   if (last_hs) state_n = DRAIN;
      DRAIN:   if ((outst == '0) && !resp_q_valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Burst address / remaining beats / outstanding beats bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_addr     <= '0;
      rem          <= '0;
      outst        <= '0;
      resp_q_valid <= 1'b0;
    end else begin
      if (start) begin
        cur_addr <= start_addr;
        rem      <= len_beats;
      end else if (hs) begin
        cur_addr <= cur_addr + (DDR_ADDR_LEN'(burst) << BEAT_SHIFT);
        rem      <= rem - burst;
      end
      outst <= outst + (hs ? CNT_W'(burst) : CNT_W'(0))
                     - (resp_acc ? CNT_W'(1) : CNT_W'(0));
      resp_q_valid <= resp_acc;
    end
  end

  // Response beat staging register; gives the one-cycle write-to-visible delay.
  always_ff @(posedge clk) begin
    if (resp_acc) resp_q_data <= rd_resp_data;
  end

  sync_fifo_fwft #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (resp_q_data),
    .pop       (fifo_pop),
    .pop_data  (ddr_fifo_data),
    .empty     (ddr_fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

`ifdef DDR_WEIGHT_READER_STATS_EN
  // Saturating counters of pushed beats and credit-stalled ISSUE cycles.
  always_ff @(posedge clk) begin
    if (!rst_n || conf) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      if (fifo_push && (stat_beats != '1)) stat_beats <= stat_beats + 32'd1;
      if ((state == ISSUE) && !credit_ok && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule : ddr_weight_reader
`default_nettype wire

// File: tb/tb_ddr_weight_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_weight_reader
//  Description : Directed self-checking bench for ddr_weight_reader with a
//                fixed-latency memory responder and a request log.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ddr_weight_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         conf;
  logic [31:0]  ddr_st_addr;
  logic [23:0]  ddr_len;
  logic         rd_req_valid;
  logic         rd_req_ready;
  logic [31:0]  rd_req_addr;
  logic [7:0]   rd_req_beats;
  logic         rd_resp_valid;
  logic [511:0] rd_resp_data;
  logic         ddr_fifo_empty;
  logic         ddr_fifo_req;
  logic [511:0] ddr_fifo_data;
  logic         idle;
`ifdef DDR_WEIGHT_READER_STATS_EN
  logic [31:0]  stat_beats;
  logic [31:0]  stat_stall;
`endif

  int total  = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [31:0] log_addr  [$];
  int          log_beats [$];
  logic [31:0] beat_q    [$];
  int          due_q     [$];

  ddr_weight_reader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .conf           (conf),
    .ddr_st_addr    (ddr_st_addr),
    .ddr_len        (ddr_len),
    .rd_req_valid   (rd_req_valid),
    .rd_req_ready   (rd_req_ready),
    .rd_req_addr    (rd_req_addr),
    .rd_req_beats   (rd_req_beats),
    .rd_resp_valid  (rd_resp_valid),
    .rd_resp_data   (rd_resp_data),
    .ddr_fifo_empty (ddr_fifo_empty),
    .ddr_fifo_req   (ddr_fifo_req),
    .ddr_fifo_data  (ddr_fifo_data),
    .idle           (idle)
`ifdef DDR_WEIGHT_READER_STATS_EN
    ,
    .stat_beats     (stat_beats),
    .stat_stall     (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] pat(input logic [31:0] a);
    return {16{a}};
  endfunction

  // Memory model: logs each handshake, returns beats 3 cycles later in order.
  initial begin
    rd_resp_valid = 1'b0;
    rd_resp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        beat_q.delete();
        due_q.delete();
        rd_resp_valid = 1'b0;
        rd_resp_data  = '0;
      end else begin
        if (rd_req_valid && rd_req_ready) begin
          log_addr.push_back(rd_req_addr);
          log_beats.push_back(int'(rd_req_beats));
          for (int i = 0; i < int'(rd_req_beats); i++) begin
            beat_q.push_back(rd_req_addr + 32'(i * 64));
            due_q.push_back(cyc + 3);
          end
        end
        if (beat_q.size() > 0 && due_q[0] <= cyc) begin
          rd_resp_valid = 1'b1;
          rd_resp_data  = pat(beat_q.pop_front());
          void'(due_q.pop_front());
        end else begin
          rd_resp_valid = 1'b0;
          rd_resp_data  = '0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic [23:0] l);
    @(negedge clk);
    ddr_st_addr = a;
    ddr_len     = l;
    conf        = 1'b1;
    @(negedge clk);
    conf        = 1'b0;
  endtask

  // Pops n beats, checking each head against the address-ordered pattern.
  task automatic pop_n(input string tag, input int n, input logic [31:0] base, input int budget);
    int got = 0;
    int k   = 0;
    logic [31:0] ea;
    while (got < n && k < budget) begin
      @(negedge clk);
      ddr_fifo_req = 1'b0;
      if (!ddr_fifo_empty) begin
        ea = base + 32'(got * 64);
        total++;
        assert (ddr_fifo_data === pat(ea)) passes++;
        else begin
          fails++;
          $error("FAIL %s_data[%0d]: observed %0h expected %0h", tag, got, ddr_fifo_data[31:0], ea);
        end
        got++;
        ddr_fifo_req = 1'b1;
      end
      k++;
    end
    @(negedge clk);
    ddr_fifo_req = 1'b0;
    chk({tag, "_count"}, 64'(got), 64'(n));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (!idle && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(idle), 64'd1);
  endtask

  function automatic int sum_beats();
    int s = 0;
    foreach (log_beats[i]) s += log_beats[i];
    return s;
  endfunction

  task automatic clear_log();
    log_addr.delete();
    log_beats.delete();
  endtask

  initial begin
    rst_n        = 1'b0;
    conf         = 1'b0;
    ddr_st_addr  = '0;
    ddr_len      = '0;
    rd_req_ready = 1'b0;
    ddr_fifo_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_valid", 64'(rd_req_valid), 64'd0);
    chk("rst_addr",  64'(rd_req_addr),  64'd0);
    chk("rst_beats", 64'(rd_req_beats), 64'd0);
    chk("rst_empty", 64'(ddr_fifo_empty), 64'd1);
    chk("rst_data",  64'(ddr_fifo_data[63:0]), 64'd0);
    chk("rst_idle",  64'(idle), 64'd1);
    rst_n = 1'b1;

    // 1: 4 KB aligned transfer -> four 16-beat bursts.
    clear_log();
    rd_req_ready = 1'b1;
    start_xfer(32'h1000, 24'd4096);
    pop_n("t1", 64, 32'h1000, 400);
    wait_idle("t1_idle", 50);
    chk("t1_nreq", 64'(log_addr.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk("t1_addr",  64'(log_addr[i]),  64'(32'h1000 + 32'(i * 32'h400)));
      chk("t1_beats", 64'(log_beats[i]), 64'd16);
    end

    // 2: unaligned-page start -> 1 beat, then 3 beats after the 4 KB line.
    clear_log();
    start_xfer(32'h0FC0, 24'd200);
    pop_n("t2", 4, 32'h0FC0, 100);
    wait_idle("t2_idle", 50);
    chk("t2_nreq", 64'(log_addr.size()), 64'd2);
    if (log_addr.size() == 2) begin
      chk("t2_addr0",  64'(log_addr[0]),  64'h0FC0);
      chk("t2_beats0", 64'(log_beats[0]), 64'd1);
      chk("t2_addr1",  64'(log_addr[1]),  64'h1000);
      chk("t2_beats1", 64'(log_beats[1]), 64'd3);
    end

    // 3: consumer stalled -> credit caps requests at the FIFO depth.
    clear_log();
    start_xfer(32'h2000, 24'd8192);
    repeat (60) @(negedge clk);
    chk("t3_held_beats", 64'(sum_beats()), 64'd64);
    chk("t3_held_valid", 64'(rd_req_valid), 64'd0);
    chk("t3_held_empty", 64'(ddr_fifo_empty), 64'd0);
    pop_n("t3", 128, 32'h2000, 800);
    wait_idle("t3_idle", 50);
    chk("t3_total_beats", 64'(sum_beats()), 64'd128);

    // 4a: zero length -> nothing happens.
    clear_log();
    start_xfer(32'h7000, 24'd0);
    repeat (5) @(negedge clk);
    chk("t4_len0_idle", 64'(idle), 64'd1);
    chk("t4_len0_nreq", 64'(log_addr.size()), 64'd0);

    // 4b: conf while busy is ignored.
    rd_req_ready = 1'b0;
    start_xfer(32'h3000, 24'd2048);
    start_xfer(32'h8000, 24'd64);
    rd_req_ready = 1'b1;
    pop_n("t4", 32, 32'h3000, 300);
    wait_idle("t4_idle", 50);
    chk("t4_nreq", 64'(log_addr.size()), 64'd2);
    if (log_addr.size() == 2) begin
      chk("t4_addr0", 64'(log_addr[0]), 64'h3000);
      chk("t4_addr1", 64'(log_addr[1]), 64'h3400);
    end

    // 5: backpressure on the request port -> request held stable.
    clear_log();
    rd_req_ready = 1'b0;
    start_xfer(32'h4000, 24'd640);
    for (int i = 0; i < 5; i++) begin
      chk("t5_valid", 64'(rd_req_valid), 64'd1);
      chk("t5_addr",  64'(rd_req_addr),  64'h4000);
      chk("t5_beats", 64'(rd_req_beats), 64'd10);
      @(negedge clk);
    end
    chk("t5_nreq_held", 64'(log_addr.size()), 64'd0);
    rd_req_ready = 1'b1;
    pop_n("t5", 10, 32'h4000, 100);
    wait_idle("t5_idle", 50);

    // 6: reset in the middle of a transfer, then a fresh transfer.
    clear_log();
    start_xfer(32'h5000, 24'd4096);
    repeat (10) @(negedge clk);
    chk("t6_busy", 64'(idle), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_empty", 64'(ddr_fifo_empty), 64'd1);
    chk("t6_rst_idle",  64'(idle), 64'd1);
    chk("t6_rst_valid", 64'(rd_req_valid), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_post_empty", 64'(ddr_fifo_empty), 64'd1);
    clear_log();
    start_xfer(32'h6000, 24'd256);
    pop_n("t6", 4, 32'h6000, 100);
    wait_idle("t6_idle", 50);
    chk("t6_nreq", 64'(log_addr.size()), 64'd1);
    repeat (5) @(negedge clk);
    chk("t6_final_empty", 64'(ddr_fifo_empty), 64'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule : tb_ddr_weight_reader
`default_nettype wire
